alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, handshaked integer execute unit for the RISC-V core. It extends the combinational ALU with XOR, unsigned compare, shifts, and iterative multiply and unsigned divide/remainder. Single-cycle ops return a registered result one cycle after issue. Multiply and divide run a WIDTH-step shift-add or restoring loop. It sits between operand fetch and writeback, and issue stalls on `in_ready`.

## Interface
- `WIDTH`, 32: operand/result width. Power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived, do not override).

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  unit can accept (high only in IDLE)
- `op`  in  4  operation select, encoding below
- `a`, `b`  in  WIDTH each  operands
- `out_valid`  out  1  result/flags valid
- `out_ready`  in  1  consumer accepts result
- `result`  out  WIDTH  registered result
- `z`, `n`, `v`, `c`  out  1 each  zero, negative, overflow, carry flags
- `err`  out  1  illegal/unsupported op flag

## Operation
- Op encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT (signed), 0110 SLTU
  - 0111 SLL, 1000 SRL, 1001 SRA
  - 1010 MUL (low half), 1011 MULHU (high half, unsigned)
  - 1100 DIVU, 1101 REMU
  - 1110, 1111 illegal
- Shifts use `b[SHW-1:0]`; upper bits of `b` are ignored.
- SUB computes `a + ~b + 1`.
- `c` is the carry out of the WIDTH-bit add: for SUB, `c=1` means no borrow (`a ≥ b` unsigned).
- `v` = operands' effective signs equal and result sign differs (ADD uses `b`, SUB uses `~b`).
- `c` and `v` are 0 for all ops other than ADD/SUB.
- `z` = (result==0), `n` = result[WIDTH-1], for every op including illegal ones.
- Multiply: unsigned shift-add over WIDTH iterations into a 2·WIDTH product. MUL returns product[WIDTH-1:0], MULHU returns product[2·WIDTH-1:WIDTH].
- Divide: restoring, one quotient bit per iteration.
  - Divide by zero: quotient = all ones, remainder = `a`, `err`=0.
- Illegal op: result 0 (so `z`=1), `err`=1, single-cycle latency.
- FSM:
  - IDLE: `in_ready`=1. On `in_valid`, a fast op goes to DONE with the result registered. MUL/DIV ops latch operands, clear the iteration counter and go to BUSY.
  - BUSY: one iteration per cycle. When the counter reaches WIDTH-1, write the result and go to DONE.
  - DONE: `out_valid`=1; `result`/flags held stable. On `out_ready` go to IDLE.
- Operands are sampled only at the accept edge; input changes during BUSY are ignored.

## Timing
- Accept edge = rising `clk` with `in_valid && in_ready`.
- Fast ops: `out_valid` high in the cycle after accept (latency 1).
- MUL/MULHU/DIVU/REMU: `out_valid` first high WIDTH+1 cycles after accept (33 at WIDTH=32).
- Max throughput is one fast op per 2 cycles if `out_ready` is held high. There is no accept in the same cycle as the DONE→IDLE transition.
- `out_valid` stays high and outputs stay stable until `out_ready`. `out_ready` while not in DONE is ignored.
- Reset values:
  - state IDLE
  - `in_ready`=1, `out_valid`=0
  - `result`=0, `z`=`n`=`v`=`c`=0, `err`=0
  - counter=0
- `rst` during BUSY or DONE aborts the operation and discards the result. The next cycle is IDLE with reset values.
- `rst` has priority over any concurrent accept.

## Configuration
- `ALU_MDU_DIV_EN` defined: divider datapath built; DIVU/REMU behave as above.
- Not defined: no divider logic. DIVU/REMU are treated as illegal ops (result 0, `err`=1, latency 1). Multiply is unaffected.

## Test plan
- ADD a=0x7FFFFFFF, b=0x1 → result 0x80000000, v=1, n=1, c=0, z=0, out_valid at cycle+1.
- SUB a=5, b=7 → 0xFFFFFFFE, n=1, c=0, v=0. SLT a=0xFFFFFFFF, b=1 → 1. SLTU same operands → 0. SRA a=0x80000000, b=0x24 → 0xF8000000.
- MUL and MULHU a=b=0xFFFFFFFF → 0x00000001 and 0xFFFFFFFE respectively, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
- DIVU 100/7 → 14, REMU → 2. DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5. With macro undefined, DIVU → 0 with err=1, z=1.
- Backpressure and reset: hold out_ready=0 for 10 cycles after a MUL completes → result stable, in_ready=0. Assert rst mid-BUSY → next cycle out_valid=0, in_ready=1, result=0. Op 1111 → err=1, result 0.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked ALU with iterative shift-add multiply and restoring divide.
// Define ALU_MDU_DIV_EN to build the DIVU/REMU datapath; otherwise they are illegal.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             c,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic [1:0]         state;
    logic [SHW-1:0]     cnt;
    logic [3:0]         lop;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] f_res;
    logic             f_v;
    logic             f_c;
    logic             f_err;
    logic             is_long;

    logic [WIDTH:0]     m_add;
    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH-1:0]   l_res;

`ifdef ALU_MDU_DIV_EN
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   d_shift;
    logic [WIDTH:0]   d_diff;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] r_nx;
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    assign add_b = (op == OP_SUB) ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, add_b}
                 + {{WIDTH{1'b0}}, (op == OP_SUB)};
    assign sh    = b[SHW-1:0];

    always_comb begin
        f_res   = '0;
        f_v     = 1'b0;
        f_c     = 1'b0;
        f_err   = 1'b0;
        is_long = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB: begin
                f_res = sum[WIDTH-1:0];
                f_c   = sum[WIDTH];
                f_v   = (a[WIDTH-1] == add_b[WIDTH-1])
                     && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   f_res = a & b;
            OP_OR:    f_res = a | b;
            OP_XOR:   f_res = a ^ b;
            OP_SLT:   f_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  f_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:   f_res = a << sh;
            OP_SRL:   f_res = a >> sh;
            OP_SRA:   f_res = $unsigned($signed(a) >>> sh);
            OP_MUL, OP_MULHU: is_long = 1'b1;
`ifdef ALU_MDU_DIV_EN
            OP_DIVU, OP_REMU: is_long = 1'b1;
`else
            OP_DIVU, OP_REMU: f_err = 1'b1;
`endif
            default:  f_err = 1'b1;
        endcase
    end

    // prod holds {partial sum, remaining multiplier bits}, shifted right each step
    assign m_add   = {1'b0, prod[2*WIDTH-1:WIDTH]}
                   + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign prod_nx = {m_add, prod[WIDTH-1:1]};

`ifdef ALU_MDU_DIV_EN
    assign d_shift = {rem, quo[WIDTH-1]};
    assign d_diff  = d_shift - {1'b0, dvsr};

    always_comb begin
        if (!d_diff[WIDTH]) begin
            r_nx = d_diff[WIDTH-1:0];
            q_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
            r_nx = d_shift[WIDTH-1:0];
            q_nx = {quo[WIDTH-2:0], 1'b0};
        end
    end
`endif

    always_comb begin
        l_res = prod_nx[WIDTH-1:0];
        unique case (lop)
            OP_MULHU: l_res = prod_nx[2*WIDTH-1:WIDTH];
`ifdef ALU_MDU_DIV_EN
            OP_DIVU:  l_res = q_nx;
            OP_REMU:  l_res = r_nx;
`endif
            default:  l_res = prod_nx[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            lop    <= '0;
            mcand  <= '0;
            prod   <= '0;
            result <= '0;
            z      <= 1'b0;
            n      <= 1'b0;
            v      <= 1'b0;
            c      <= 1'b0;
            err    <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            dvsr   <= '0;
            quo    <= '0;
            rem    <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_long) begin
                            lop   <= op;
                            mcand <= a;
                            prod  <= {{WIDTH{1'b0}}, b};
                            cnt   <= '0;
`ifdef ALU_MDU_DIV_EN
                            dvsr  <= b;
                            quo   <= a;
                            rem   <= '0;
`endif
                            state <= S_BUSY;
                        end else begin
                            result <= f_res;
                            z      <= (f_res == '0);
                            n      <= f_res[WIDTH-1];
                            v      <= f_v;
                            c      <= f_c;
                            err    <= f_err;
                            state  <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    prod <= prod_nx;
`ifdef ALU_MDU_DIV_EN
                    quo  <= q_nx;
                    rem  <= r_nx;
`endif
                    if (cnt == LAST) begin
                        result <= l_res;
                        z      <= (l_res == '0);
                        n      <= l_res[WIDTH-1];
                        v      <= 1'b0;
                        c      <= 1'b0;
                        err    <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized and directed checks of alu_mdu against an
// arithmetic reference model (WIDTH=32).
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        z, n, v, c, err;

    int tests = 0;
    int fails = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .z(z), .n(n), .v(v), .c(c), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit long_op(input logic [3:0] o);
`ifdef ALU_MDU_DIV_EN
        return (o >= 4'd10 && o <= 4'd13);
`else
        return (o == 4'd10 || o == 4'd11);
`endif
    endfunction

    // flags packed as {z, n, v, c, err}
    function automatic void model(input logic [3:0] o,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [4:0] f);
        longint          sx  = longint'($signed(x));
        longint          sy  = longint'($signed(y));
        longint unsigned ux  = 64'(x);
        longint unsigned uy  = 64'(y);
        longint          lim = 64'sd2147483647;
        longint          s;
        logic vv = 1'b0;
        logic cc = 1'b0;
        logic ee = 1'b0;
        case (o)
            4'd0: begin
                r = x + y; s = sx + sy;
                cc = (ux + uy) > 64'hFFFF_FFFF;
                vv = (s > lim) || (s < -lim - 1);
            end
            4'd1: begin
                r = x - y; s = sx - sy;
                cc = (ux >= uy);
                vv = (s > lim) || (s < -lim - 1);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = (sx < sy) ? 32'd1 : 32'd0;
            4'd6: r = (ux < uy) ? 32'd1 : 32'd0;
            4'd7: r = x << y[4:0];
            4'd8: r = x >> y[4:0];
            4'd9: r = 32'(sx >>> y[4:0]);
            4'd10: r = 32'(ux * uy);
            4'd11: r = 32'((ux * uy) >> 32);
`ifdef ALU_MDU_DIV_EN
            4'd12: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd13: r = (y == 0) ? x : x % y;
`endif
            default: begin r = 32'd0; ee = 1'b1; end
        endcase
        f = {(r == 32'd0), r[31], vv, cc, ee};
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat,
                          output logic [31:0] r, output logic [4:0] f,
                          output bit rdy_seen);
        int k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 4'($urandom);
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        if (in_ready) rdy_seen = 1'b1;
        r = result;
        f = {z, n, v, c, err};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL reset_hs got %b exp 10", {in_ready, out_valid});
        end
        tests++;
        if (result !== 32'd0) begin
            fails++;
            $display("FAIL reset_result got %h exp 0", result);
        end
        tests++;
        if ({z, n, v, c, err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags got %b exp 00000", {z, n, v, c, err});
        end
    endtask

    typedef struct {
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t q[$];
        int lat;
        logic [31:0] r;
        logic [4:0] f;
        bit rs;
        q.push_back('{4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b01100, 1});
        q.push_back('{4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 5'b01000, 1});
        q.push_back('{4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 5'b00000, 1});
        q.push_back('{4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'b10000, 1});
        q.push_back('{4'd9, 32'h8000_0000, 32'h24, 32'hF800_0000, 5'b01000, 1});
        q.push_back('{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 5'b00000, 33});
        q.push_back('{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                      5'b01000, 33});
        q.push_back('{4'd15, 32'd9, 32'd3, 32'd0, 5'b10001, 1});
`ifdef ALU_MDU_DIV_EN
        q.push_back('{4'd12, 32'd100, 32'd7, 32'd14, 5'b00000, 33});
        q.push_back('{4'd13, 32'd100, 32'd7, 32'd2, 5'b00000, 33});
        q.push_back('{4'd12, 32'd5, 32'd0, 32'hFFFF_FFFF, 5'b01000, 33});
        q.push_back('{4'd13, 32'd5, 32'd0, 32'd5, 5'b00000, 33});
`else
        q.push_back('{4'd12, 32'd100, 32'd7, 32'd0, 5'b10001, 1});
        q.push_back('{4'd13, 32'd100, 32'd7, 32'd0, 5'b10001, 1});
`endif
        foreach (q[i]) begin
            run_op(q[i].o, q[i].x, q[i].y, lat, r, f, rs);
            tests++;
            if ({r, f} !== {q[i].r, q[i].f}) begin
                fails++;
                $display("FAIL directed[%0d] op=%0d got %h/%b exp %h/%b",
                         i, q[i].o, r, f, q[i].r, q[i].f);
            end
            tests++;
            if (lat !== q[i].lat || rs) begin
                fails++;
                $display("FAIL directed_lat[%0d] got lat=%0d rdy=%0b exp lat=%0d rdy=0",
                         i, lat, rs, q[i].lat);
            end
        end
    endtask

    task automatic test_random(input int cnt, input bit longs);
        int lat;
        logic [31:0] r, er, x, y;
        logic [4:0] f, ef;
        logic [3:0] o;
        bit rs;
        for (int i = 0; i < cnt; i++) begin
            if (longs) o = 4'(10 + $urandom_range(0, 3));
            else o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'(y[3:0]);
                2: x = 32'h7FFF_FFFF;
                default: ;
            endcase
            model(o, x, y, er, ef);
            run_op(o, x, y, lat, r, f, rs);
            tests++;
            if ({r, f} !== {er, ef}) begin
                fails++;
                $display("FAIL random op=%0d a=%h b=%h got %h/%b exp %h/%b",
                         o, x, y, r, f, er, ef);
            end
            tests++;
            if (lat !== (long_op(o) ? 33 : 1) || rs) begin
                fails++;
                $display("FAIL random_lat op=%0d got %0d rdy=%0b exp %0d",
                         o, lat, rs, long_op(o) ? 33 : 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        logic [31:0] r0;
        bit bad = 1'b0;
        op = 4'd10; a = 32'd12345; b = 32'd678; in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1; k++;
        end
        r0 = result;
        tests++;
        if (r0 !== 32'd8369910) begin
            fails++;
            $display("FAIL bp_result got %h exp %h", r0, 32'd8369910);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; op = 4'd0;
            @(posedge clk); #1;
            if (!out_valid || in_ready || result !== r0) bad = 1'b1;
        end
        in_valid = 1'b0;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL bp_hold got ov=%0b rdy=%0b res=%h exp 1/0/%h",
                     out_valid, in_ready, result, r0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL bp_release got %b exp 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_reset_busy();
        int lat;
        logic [31:0] r;
        logic [4:0] f;
        bit rs;
        op = 4'd11; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; op = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        tests++;
        if ({out_valid, in_ready, result, err} !== {2'b01, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL rst_busy got ov=%0b rdy=%0b res=%h exp 0/1/0",
                     out_valid, in_ready, result);
        end
        run_op(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat, r, f, rs);
        tests++;
        if (r !== 32'hFF00_FF00 || lat !== 1) begin
            fails++;
            $display("FAIL rst_after got %h lat=%0d exp ff00ff00 lat=1", r, lat);
        end
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        bit bad = 1'b0;
        op = 4'd0; a = 32'd40; b = 32'd2;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                seen++;
                if (result !== 32'd42) bad = 1'b1;
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if (seen !== 5 || bad) begin
            fails++;
            $display("FAIL back_to_back got %0d results bad=%0b exp 5", seen, bad);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(60, 1'b0);
        test_random(12, 1'b1);
        test_backpressure();
        test_reset_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
